ring_freq_meter: RTL and testbench

//  Measures N free-running ring-oscillator clocks against the board clock i_clk.

---
 rtl/ring_freq_meter.sv | 128 ++++++++++++
 tb/tb_ring_freq_meter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ring_freq_meter.sv
// ring_freq_meter: gated-window edge counter for N ring oscillators via Gray-coded CDC; define RING_MEAS_OVF_EN for sticky per-channel wrap flags
module ring_freq_meter #(
  parameter int pCHANNELS = 4,
  parameter int pCNT_W    = 16,
  parameter int pWINDOW   = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [pCHANNELS-1:0] i_ring,
  input  logic                 i_start,
  input  logic [3:0]           i_chan,
  input  logic [1:0]           i_bsel,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_valid,
  output logic [7:0]           o_byte
);
  localparam int WC_W = $clog2(pWINDOW);
  typedef enum logic [1:0] {IDLE, ARM, WIN, DONE} state_t;
  state_t state, state_nx;
  logic [pCHANNELS-1:0][pCNT_W-1:0] g, g_m, g_s, b, s, e, d;
  logic [WC_W-1:0] wc;
  logic last;
  logic [pCNT_W-1:0] sel;
  logic [31:0] sh;
  assign last = wc == WC_W'(pWINDOW - 1);
  for (genvar k = 0; k < pCHANNELS; k++) begin : g_ring
    logic [1:0] rs;
    logic [pCNT_W-1:0] cnt, gr, nx;
    assign nx = cnt + pCNT_W'(1);
    assign g[k] = gr;
    // ring-clocked count with locally synchronised reset; only the Gray copy leaves this domain
    always_ff @(posedge i_ring[k]) begin
      rs  <= {rs[0], i_rst};
      cnt <= rs[1] ? '0 : nx;
      gr  <= rs[1] ? '0 : nx ^ (nx >> 1);
    end
  end
  // two-stage synchroniser of every Gray counter into i_clk
  always_ff @(posedge i_clk) begin
    g_m <= g;
    g_s <= g_m;
  end
  // Gray to binary: bit i is the XOR of all Gray bits at or above i
  always_comb begin
    b = '0;
    for (int k = 0; k < pCHANNELS; k++)
      for (int i = 0; i < pCNT_W; i++) b[k][i] = ^(g_s[k] >> i);
  end
  // state register plus start/end snapshots, window counter and latched deltas
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      wc      <= '0;
      s       <= '0;
      e       <= '0;
      d       <= '0;
      o_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ARM) begin
        s  <= b;
        wc <= '0;
      end
      if (state == WIN) begin
        wc <= wc + WC_W'(1);
        if (last) e <= b;
      end
      if (state == DONE) begin
        for (int k = 0; k < pCHANNELS; k++) d[k] <= e[k] - s[k];
        o_valid <= 1'b1;
      end
    end
  end
  // next state and status decode
  always_comb begin
    state_nx = state == IDLE ? (i_start ? ARM : IDLE) :
               state == ARM  ? WIN :
               state == WIN  ? (last ? DONE : WIN) : IDLE;
    o_busy   = state == ARM || state == WIN;
    o_done   = state == DONE;
  end
`ifdef RING_MEAS_OVF_EN
  logic [pCHANNELS-1:0] ov, pm, cm;
  logic [pCNT_W-1:0] df;
  logic so;
  // MSB of the running delta for each channel
  always_comb begin
    cm = '0;
    df = '0;
    for (int k = 0; k < pCHANNELS; k++) begin
      df    = b[k] - s[k];
      cm[k] = df[pCNT_W-1];
    end
  end
  // sticky wrap flag: running delta MSB falling during the window means it passed 2**pCNT_W
  always_ff @(posedge i_clk) begin
    if (i_rst || state == ARM) begin
      ov <= '0;
      pm <= '0;
    end else if (state == WIN) begin
      pm <= cm;
      ov <= ov | (pm & ~cm);
    end
  end
  // byte readout; a wrapped channel shows FF in its top byte
  always_comb begin
    sel = '0;
    so  = 1'b0;
    for (int k = 0; k < pCHANNELS; k++)
      if (i_chan == 4'(k)) begin
        sel = d[k];
        so  = ov[k];
      end
    sh     = 32'(sel) >> {i_bsel, 3'b000};
    o_byte = (so && i_bsel == 2'((pCNT_W - 1) / 8)) ? 8'hFF : sh[7:0];
  end
`else
  // byte readout; unknown channels and bytes past the counter width read zero
  always_comb begin
    sel = '0;
    for (int k = 0; k < pCHANNELS; k++)
      if (i_chan == 4'(k)) sel = d[k];
    sh     = 32'(sel) >> {i_bsel, 3'b000};
    o_byte = sh[7:0];
  end
`endif
endmodule

// File: tb/tb_ring_freq_meter.sv
// tb_ring_freq_meter: directed bench for ring_freq_meter (main 4ch/16b/1000 instance, small 2ch/8b/100 wrap instance)
`timescale 1ns/1ps
module tb_ring_freq_meter;
  logic i_clk = 0, i_rst = 1, i_start = 0, w_start = 0;
  logic r0 = 0, r1 = 0, r2 = 0, r3 = 0, r3_en = 1, w0 = 0, w1 = 0;
  logic [3:0] i_chan = 0, w_chan = 0;
  logic [1:0] i_bsel = 0, w_bsel = 0;
  logic o_busy, o_done, o_valid, w_busy, w_done, w_valid;
  logic [7:0] o_byte, w_byte;
  int pass = 0, total = 0, dcnt = 0;

  ring_freq_meter #(.pCHANNELS(4), .pCNT_W(16), .pWINDOW(1000)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ring({r3, r2, r1, r0}), .i_start(i_start),
    .i_chan(i_chan), .i_bsel(i_bsel), .o_busy(o_busy), .o_done(o_done),
    .o_valid(o_valid), .o_byte(o_byte));

  ring_freq_meter #(.pCHANNELS(2), .pCNT_W(8), .pWINDOW(100)) u_wrap (
    .i_clk(i_clk), .i_rst(i_rst), .i_ring({w1, w0}), .i_start(w_start),
    .i_chan(w_chan), .i_bsel(w_bsel), .o_busy(w_busy), .o_done(w_done),
    .o_valid(w_valid), .o_byte(w_byte));

  always #5 i_clk = ~i_clk;
  initial begin #0.3; forever #1.0 r0 = ~r0; end
  initial begin #0.3; forever #2.0 r1 = ~r1; end
  initial begin #0.3; forever #4.0 r2 = ~r2; end
  initial begin #0.3; forever #10.0 r3 = r3_en ? ~r3 : 1'b0; end
  initial begin #0.3; forever #2.0 w0 = ~w0; end
  initial begin #0.3; forever #0.5 w1 = ~w1; end

  always @(negedge i_clk) if (o_done === 1'b1) dcnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 2ms", $time);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start;
    @(negedge i_clk);
    i_start = 1;
    @(posedge i_clk);
    #1 i_start = 0;
  endtask

  task automatic wait_done(input bit w, input int lim, output int n, output bit hit);
    n = 0;
    hit = 0;
    while (!hit && n < lim) begin
      @(posedge i_clk);
      #1;
      n++;
      hit = w ? w_done : o_done;
    end
  endtask

  task automatic rd16(input logic [3:0] c, output int v);
    logic [7:0] lo;
    i_chan = c;
    i_bsel = 0;
    #0.1 lo = o_byte;
    i_bsel = 1;
    #0.1 v = {16'd0, o_byte, lo};
  endtask

  task automatic test_reset;
    i_rst = 1;
    step(20);
    total++; if (o_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", o_busy); else pass++;
    total++; if (o_done !== 1'b0) $display("FAIL rst_done got %b want 0", o_done); else pass++;
    total++; if (o_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", o_valid); else pass++;
    total++; if (o_byte !== 8'h00) $display("FAIL rst_byte got %h want 00", o_byte); else pass++;
    i_rst = 0;
    step(5);
    total++; if (o_busy !== 1'b0) $display("FAIL idle_busy got %b want 0", o_busy); else pass++;
  endtask

  task automatic test_basic;
    int n, v;
    bit hit;
    int exp_d[4] = '{5000, 2500, 1250, 500};
    pulse_start;
    total++; if (o_busy !== 1'b1) $display("FAIL arm_busy got %b want 1", o_busy); else pass++;
    wait_done(0, 1100, n, hit);
    total++; if (!hit || n != 1001) $display("FAIL latency got %0d (hit %b) want 1001", n, hit); else pass++;
    step(1);
    total++; if (o_valid !== 1'b1) $display("FAIL valid got %b want 1", o_valid); else pass++;
    total++; if (o_busy !== 1'b0) $display("FAIL post_busy got %b want 0", o_busy); else pass++;
    for (int c = 0; c < 4; c++) begin
      rd16(4'(c), v);
      total++;
      if (v < exp_d[c] - 2 || v > exp_d[c] + 2) $display("FAIL delta%0d got %0d want %0d+/-2", c, v, exp_d[c]);
      else pass++;
    end
    i_chan = 0; i_bsel = 1;
    #0.1;
    total++; if (o_byte !== 8'h13) $display("FAIL ch0_b1 got %h want 13", o_byte); else pass++;
    i_bsel = 0;
    #0.1;
    total++; if (o_byte < 8'h86 || o_byte > 8'h8A) $display("FAIL ch0_b0 got %h want 88+/-2", o_byte); else pass++;
  endtask

  task automatic test_busy_ignore;
    int d0, n;
    bit hit;
    d0 = dcnt;
    pulse_start;
    step(499);
    pulse_start;
    step(600);
    total++; if (dcnt - d0 != 1) $display("FAIL busy_ignore dones got %0d want 1", dcnt - d0); else pass++;
    total++; if (o_busy !== 1'b0) $display("FAIL busy_requeue got %b want 0", o_busy); else pass++;
    pulse_start;
    wait_done(0, 1100, n, hit);
    total++; if (!hit || n != 1001) $display("FAIL fresh_start got %0d (hit %b) want 1001", n, hit); else pass++;
    step(1);
  endtask

  task automatic test_readout_edges;
    i_chan = 7; i_bsel = 0;
    #0.1;
    total++; if (o_byte !== 8'h00) $display("FAIL chan7_b0 got %h want 00", o_byte); else pass++;
    i_bsel = 1;
    #0.1;
    total++; if (o_byte !== 8'h00) $display("FAIL chan7_b1 got %h want 00", o_byte); else pass++;
    i_chan = 0; i_bsel = 3;
    #0.1;
    total++; if (o_byte !== 8'h00) $display("FAIL bsel3 got %h want 00", o_byte); else pass++;
    i_bsel = 2;
    #0.1;
    total++; if (o_byte !== 8'h00) $display("FAIL bsel2 got %h want 00", o_byte); else pass++;
    i_chan = 3; i_bsel = 1;
    #0.1;
    total++; if (o_byte !== 8'h01) $display("FAIL ch3_b1 got %h want 01", o_byte); else pass++;
  endtask

  task automatic test_reset_mid;
    int d0, v;
    d0 = dcnt;
    pulse_start;
    step(399);
    @(negedge i_clk);
    i_rst = 1;
    @(posedge i_clk);
    #1 i_rst = 0;
    total++; if (o_busy !== 1'b0) $display("FAIL mid_busy got %b want 0", o_busy); else pass++;
    total++; if (o_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", o_valid); else pass++;
    rd16(0, v);
    total++; if (v != 0) $display("FAIL mid_delta got %0d want 0", v); else pass++;
    step(1100);
    total++; if (dcnt != d0) $display("FAIL mid_done got %0d want 0", dcnt - d0); else pass++;
    total++; if (o_valid !== 1'b0) $display("FAIL mid_valid_late got %b want 0", o_valid); else pass++;
  endtask

  task automatic test_wrap;
    int n;
    bit hit;
    @(negedge i_clk);
    w_start = 1;
    @(posedge i_clk);
    #1 w_start = 0;
    wait_done(1, 200, n, hit);
    total++; if (!hit || n != 101) $display("FAIL wrap_latency got %0d (hit %b) want 101", n, hit); else pass++;
    step(1);
    total++; if (w_valid !== 1'b1) $display("FAIL wrap_valid got %b want 1", w_valid); else pass++;
    w_chan = 0; w_bsel = 0;
    #0.1;
    total++; if (w_byte < 8'd248 || w_byte > 8'd252) $display("FAIL wrap250 got %0d want 250+/-2", w_byte); else pass++;
    w_bsel = 1;
    #0.1;
    total++; if (w_byte !== 8'h00) $display("FAIL wrap_b1 got %h want 00", w_byte); else pass++;
    w_chan = 1; w_bsel = 0;
    #0.1;
`ifdef RING_MEAS_OVF_EN
    total++; if (w_byte !== 8'hFF) $display("FAIL wrap_ovf got %h want ff", w_byte); else pass++;
`else
    total++; if (w_byte < 8'd230 || w_byte > 8'd234) $display("FAIL wrap232 got %0d want 232+/-2", w_byte); else pass++;
`endif
  endtask

  task automatic test_back_to_back;
    int n, v;
    bit hit;
    r3_en = 0;
    step(10);
    @(negedge i_clk);
    i_start = 1;
    wait_done(0, 1100, n, hit);
    total++; if (!hit) $display("FAIL b2b_first got no done want done"); else pass++;
    wait_done(0, 1100, n, hit);
    total++; if (!hit || n != 1003) $display("FAIL b2b_period got %0d (hit %b) want 1003", n, hit); else pass++;
    step(1);
    rd16(3, v);
    total++; if (v != 0) $display("FAIL stopped_delta got %0d want 0", v); else pass++;
    rd16(0, v);
    total++; if (v < 4998 || v > 5002) $display("FAIL b2b_delta0 got %0d want 5000+/-2", v); else pass++;
    i_start = 0;
    step(1010);
    total++; if (o_busy !== 1'b0) $display("FAIL b2b_release got %b want 0", o_busy); else pass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_busy_ignore;
    test_readout_edges;
    test_reset_mid;
    test_wrap;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
